// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings and
// the helper that derives the shift-amount width from the data width.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } shift_op_e;

  function automatic int shamt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered stage of the barrel shifter: conditionally shifts by a fixed
// DIST and holds valid/data/remaining-shamt/op/tag with ready/valid handshaking.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 4,
  parameter int DIST    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               up_valid_i,
  output logic               up_ready_o,
  input  logic [WIDTH-1:0]   up_data_i,
  input  logic [SHAMT_W-1:0] up_shamt_i,
  input  logic [1:0]         up_op_i,
  input  logic [TAG_W-1:0]   up_tag_i,
  output logic               dn_valid_o,
  input  logic               dn_ready_i,
  output logic [WIDTH-1:0]   dn_data_o,
  output logic [SHAMT_W-1:0] dn_shamt_o,
  output logic [1:0]         dn_op_o,
  output logic [TAG_W-1:0]   dn_tag_o
);

  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [1:0]         op_q,    op_d;
  logic [TAG_W-1:0]   tag_q,   tag_d;

  logic             load;
  logic [WIDTH-1:0] shifted;
  shift_op_e        op_in;

  assign op_in = shift_op_e'(up_op_i);

  // The shamt MSB always belongs to this stage; earlier stages have already
  // shifted their bits out. For SRA the partial MSB still equals the operand
  // MSB because every earlier stage sign-filled.
  always_comb begin
    shifted = up_data_i;
    if (up_shamt_i[SHAMT_W-1]) begin
      case (op_in)
        OP_SLL:  shifted = {up_data_i[WIDTH-1-DIST:0], {DIST{1'b0}}};
        OP_SRL:  shifted = {{DIST{1'b0}}, up_data_i[WIDTH-1:DIST]};
        OP_SRA:  shifted = {{DIST{up_data_i[WIDTH-1]}}, up_data_i[WIDTH-1:DIST]};
        OP_ROL:  shifted = {up_data_i[WIDTH-1-DIST:0], up_data_i[WIDTH-1:WIDTH-DIST]};
        default: shifted = up_data_i;
      endcase
    end
  end

  // Accept when empty or when the current entry leaves this same cycle.
  assign up_ready_o = !valid_q || dn_ready_i;
  assign load       = up_valid_i && up_ready_o;

  // NOTE: every next-state signal takes its hold value first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    if (up_ready_o) begin
      valid_d = up_valid_i;
    end
    if (load) begin
      data_d  = shifted;
      shamt_d = {up_shamt_i[SHAMT_W-2:0], 1'b0};
      op_d    = up_op_i;
      tag_d   = up_tag_i;
    end
  end

  // NOTE: state updates use non-blocking assignments so all stages sample
  // their neighbours' pre-edge values and the pipeline shifts as one.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: payload registers are cleared as well as valid, so outputs read
      // as zero straight out of reset rather than showing stale contents.
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
    end
  end

  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;
  assign dn_shamt_o = shamt_q;
  assign dn_op_o    = op_q;
  assign dn_tag_o   = tag_q;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL): a chain of SHAMT_W shift_stage
// instances, largest distance first, with elastic ready/valid flow control.
module barrel_shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [shamt_width(WIDTH)-1:0] in_shamt,
  input  logic [1:0]                    in_op,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [TAG_W-1:0]              out_tag
);

  localparam int SHAMT_W = shamt_width(WIDTH);

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("barrel_shift_pipe: WIDTH must be a power of two from 8 to 64");
  end

  // Each generate block owns its stage's link signals; neighbours are reached
  // by block name so the ready chain never loops through one shared array.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    logic               up_valid;
    logic               up_ready;
    logic [WIDTH-1:0]   up_data;
    logic [SHAMT_W-1:0] up_shamt;
    logic [1:0]         up_op;
    logic [TAG_W-1:0]   up_tag;
    logic               dn_valid;
    logic               dn_ready;
    logic [WIDTH-1:0]   dn_data;
    logic [SHAMT_W-1:0] dn_shamt;
    logic [1:0]         dn_op;
    logic [TAG_W-1:0]   dn_tag;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
      assign up_shamt = in_shamt;
      assign up_op    = in_op;
      assign up_tag   = in_tag;
    end else begin : g_link
      assign up_valid = g_stage[k-1].dn_valid;
      assign up_data  = g_stage[k-1].dn_data;
      assign up_shamt = g_stage[k-1].dn_shamt;
      assign up_op    = g_stage[k-1].dn_op;
      assign up_tag   = g_stage[k-1].dn_tag;
    end

    if (k == SHAMT_W - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_mid
      assign dn_ready = g_stage[k+1].up_ready;
    end

    shift_stage #(
      .WIDTH  (WIDTH),
      .SHAMT_W(SHAMT_W),
      .TAG_W  (TAG_W),
      .DIST   (1 << (SHAMT_W - 1 - k))
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .up_valid_i(up_valid),
      .up_ready_o(up_ready),
      .up_data_i (up_data),
      .up_shamt_i(up_shamt),
      .up_op_i   (up_op),
      .up_tag_i  (up_tag),
      .dn_valid_o(dn_valid),
      .dn_ready_i(dn_ready),
      .dn_data_o (dn_data),
      .dn_shamt_o(dn_shamt),
      .dn_op_o   (dn_op),
      .dn_tag_o  (dn_tag)
    );
  end

  assign in_ready  = g_stage[0].up_ready;
  assign out_valid = g_stage[SHAMT_W-1].dn_valid;
  assign out_data  = g_stage[SHAMT_W-1].dn_data;
  assign out_tag   = g_stage[SHAMT_W-1].dn_tag;

  // The last stage's leftover shamt and op have no consumer.
  logic unused_tail;
  assign unused_tail = ^{g_stage[SHAMT_W-1].dn_shamt, g_stage[SHAMT_W-1].dn_op};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe: directed vector table, random
// stream, backpressure hold/drain and mid-flight reset sequences.
module tb_barrel_shift_pipe;
  import shift_pkg::*;

  localparam int WIDTH   = 32;
  localparam int TAG_W   = 4;
  localparam int SHAMT_W = 5;
  localparam int LAT     = 5;

  typedef struct {
    logic [1:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   data;
    logic [TAG_W-1:0]   tag;
    logic [WIDTH-1:0]   exp;
  } vec_t;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;

  always #5 clock = ~clock;

  barrel_shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_op    (in_op),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   stall_cnt;
  bit   check_lat;
  vec_t src_q[$];
  vec_t sb_q[$];
  int   acc_q[$];
  int   out_cyc_q[$];
  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] op,
                                                 input logic [SHAMT_W-1:0] s,
                                                 input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    case (shift_op_e'(op))
      OP_SLL:  r = d << s;
      OP_SRL:  r = d >> s;
      OP_SRA:  r = $signed(d) >>> s;
      default: r = (d << s) | (d >> (WIDTH - int'(s)));
    endcase
    return r;
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input int s, input logic [WIDTH-1:0] d,
                              input int tag, input logic [WIDTH-1:0] exp);
    vec_t v;
    v.op    = op;
    v.shamt = SHAMT_W'(s);
    v.data  = d;
    v.tag   = TAG_W'(tag);
    v.exp   = exp;
    return v;
  endfunction

  // Idle cycles drive garbage payload with in_valid low; it must be ignored.
  task automatic drive_inputs();
    if (src_q.size() > 0) begin
      in_valid = 1'b1;
      in_data  = src_q[0].data;
      in_shamt = src_q[0].shamt;
      in_op    = src_q[0].op;
      in_tag   = src_q[0].tag;
    end else begin
      in_valid = 1'b0;
      in_data  = $urandom();
      in_shamt = SHAMT_W'($urandom());
      in_op    = 2'($urandom());
      in_tag   = TAG_W'($urandom());
    end
  endtask

  task automatic cycle();
    drive_inputs();
    #1;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        vec_t e;
        int   a;
        e = sb_q.pop_front();
        a = acc_q.pop_front();
        check($sformatf("out_data tag=%0d", e.tag), out_data, e.exp);
        check($sformatf("out_tag tag=%0d", e.tag), out_tag, e.tag);
        if (check_lat) check($sformatf("latency tag=%0d", e.tag), cyc - a, LAT);
        out_cyc_q.push_back(cyc);
      end
    end
    if (in_valid && !in_ready) stall_cnt++;
    if (in_valid && in_ready) begin
      sb_q.push_back(src_q.pop_front());
      acc_q.push_back(cyc);
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((src_q.size() > 0 || sb_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check({name, "_pending_after_drain"}, src_q.size() + sb_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int               gaps;
    int               ov;
    bit               seen;
    logic [WIDTH-1:0] held_d;
    logic [TAG_W-1:0] held_t;

    vecs[0]  = mk(2'b00, 31, 32'h0000_0001, 0,  32'h8000_0000);
    vecs[1]  = mk(2'b10, 4,  32'h8000_0000, 1,  32'hF800_0000);
    vecs[2]  = mk(2'b01, 4,  32'h8000_0000, 2,  32'h0800_0000);
    vecs[3]  = mk(2'b11, 1,  32'h8000_0001, 3,  32'h0000_0003);
    vecs[4]  = mk(2'b00, 0,  32'hA5A5_A5A5, 4,  32'hA5A5_A5A5);
    vecs[5]  = mk(2'b01, 0,  32'hA5A5_A5A5, 5,  32'hA5A5_A5A5);
    vecs[6]  = mk(2'b10, 0,  32'hA5A5_A5A5, 6,  32'hA5A5_A5A5);
    vecs[7]  = mk(2'b11, 0,  32'hA5A5_A5A5, 7,  32'hA5A5_A5A5);
    vecs[8]  = mk(2'b10, 31, 32'h7FFF_FFFF, 8,  32'h0000_0000);
    vecs[9]  = mk(2'b10, 31, 32'h8000_0000, 9,  32'hFFFF_FFFF);
    vecs[10] = mk(2'b11, 8,  32'h1234_5678, 10, 32'h3456_7812);
    vecs[11] = mk(2'b01, 31, 32'hFFFF_FFFF, 11, 32'h0000_0001);
    vecs[12] = mk(2'b00, 16, 32'hA5A5_A5A5, 12, 32'hA5A5_0000);
    vecs[13] = mk(2'b11, 31, 32'h8000_0000, 13, 32'h4000_0000);
    vecs[14] = mk(2'b10, 17, 32'h8000_F000, 14, 32'hFFFF_C000);
    vecs[15] = mk(2'b11, 20, 32'h0000_000F, 15, 32'h00F0_0000);

    reset     = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    in_tag    = '0;
    check_lat = 1'b0;
    stall_cnt = 0;

    repeat (2) @(posedge clock);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, '0);
    check("reset_out_tag", out_tag, '0);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", in_ready, 1'b1);
    check("post_reset_out_valid", out_valid, 1'b0);

    // Directed table, one operation at a time with latency check.
    out_ready = 1'b1;
    check_lat = 1'b1;
    for (int i = 0; i < 16; i++) begin
      src_q.push_back(vecs[i]);
      drain(20, $sformatf("vec%0d", i));
    end

    // Back-to-back random stream: one result per cycle, in order.
    out_cyc_q.delete();
    stall_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      vec_t v;
      v.op    = 2'($urandom_range(0, 3));
      v.shamt = SHAMT_W'($urandom_range(0, WIDTH - 1));
      v.data  = $urandom();
      v.tag   = TAG_W'(i);
      v.exp   = ref_shift(v.op, v.shamt, v.data);
      src_q.push_back(v);
    end
    drain(60, "stream");
    check("stream_result_count", out_cyc_q.size(), 20);
    gaps = 0;
    for (int i = 1; i < out_cyc_q.size(); i++) begin
      if (out_cyc_q[i] != out_cyc_q[i-1] + 1) gaps++;
    end
    check("stream_gaps", gaps, 0);
    check("stream_input_stalls", stall_cnt, 0);

    // Backpressure: fill while the consumer stalls, then release.
    check_lat = 1'b0;
    out_ready = 1'b0;
    seen      = 1'b0;
    held_d    = '0;
    held_t    = '0;
    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] d;
      d = 32'h0101_0101 * (i + 1);
      src_q.push_back(mk(2'(i % 4), 3 * i + 1, d, 8 + i, ref_shift(2'(i % 4), SHAMT_W'(3 * i + 1), d)));
    end
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (out_valid) begin
        if (!seen) begin
          seen   = 1'b1;
          held_d = out_data;
          held_t = out_tag;
        end else begin
          check($sformatf("bp_hold_data cyc%0d", i), out_data, held_d);
          check($sformatf("bp_hold_tag cyc%0d", i), out_tag, held_t);
        end
      end
    end
    check("bp_entries_held", sb_q.size(), 5);
    check("bp_in_ready_full", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    if (sb_q.size() > 0) check("bp_head_data", out_data, sb_q[0].exp);
    out_ready = 1'b1;
    drive_inputs();
    #1;
    check("bp_accept_while_draining", in_ready, 1'b1);
    drain(40, "bp");

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      logic [WIDTH-1:0] d;
      d = 32'hF0F0_0F0F ^ i;
      src_q.push_back(mk(2'b11, i + 5, d, i, ref_shift(2'b11, SHAMT_W'(i + 5), d)));
    end
    repeat (3) cycle();
    check("rst_ops_in_flight", sb_q.size(), 3);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("rst_during_out_valid", out_valid, 1'b0);
    reset = 1'b0;
    sb_q.delete();
    acc_q.delete();
    #1;
    check("rst_after_in_ready", in_ready, 1'b1);
    check("rst_after_out_valid", out_valid, 1'b0);
    check("rst_after_out_data", out_data, '0);
    check("rst_after_out_tag", out_tag, '0);
    ov = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (out_valid) ov++;
    end
    check("rst_dropped_ops_no_out", ov, 0);
    check_lat = 1'b1;
    src_q.push_back(mk(2'b00, 3, 32'h0000_0001, 12, 32'h0000_0008));
    drain(20, "rst_fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
